reg_rename_file: RTL and testbench
==================================

// Module: reg_rename_file
// PURPOSE
//  Architectural register file plus rename table (dirty bit + producing ROB entry per register) for the
//  out-of-order core. Serves NUM_READ decoder source reads per cycle, with ROB-value and same-cycle-commit bypass.
//  Holds NUM_CKPT rename-table checkpoints so a mispredicted branch restores renaming without a full ROB clear.
//  Sits between decoder (reads/issue), ROB (commit, value query) and branch unit (checkpoint save/restore).
// PARAMETERS
//  NUM_READ  2   source read ports
//  ROB_BIT   4   ROB index width (`ROB_BIT from Const.v)
//  NUM_CKPT  4   rename-table checkpoint slots; CK_BIT = $clog2(NUM_CKPT)
// PORTS
//  clk_in          in   1               system clock, all state updates on posedge
//  rst_in          in   1               synchronous, active-high reset
//  rdy_in          in   1               low: hold every register and checkpoint unchanged
//  flush_all       in   1               ROB clear-up: all dirty bits and all checkpoints invalidated
//  commit_valid    in   1               ROB commits a register write this cycle
//  commit_reg_id   in   5               destination register of commit
//  commit_reg_data in   32              committed value
//  commit_rob_entry in  ROB_BIT         ROB entry being committed
//  issue_valid     in   1               decoder renames a destination this cycle
//  issue_reg_id    in   5               renamed destination register
//  issue_rob_entry in   ROB_BIT         ROB entry producing it
//  rd_id           in   5*NUM_READ      packed source register ids, port p at [5p+:5]
//  rd_val          out  32*NUM_READ     source value (valid when has_dep=0)
//  rd_has_dep      out  NUM_READ        1: value not yet available
//  rd_dep          out  ROB_BIT*NUM_READ ROB entry to wait on (0 when has_dep=0)
//  rob_q_entry     out  ROB_BIT*NUM_READ ROB entry queried per port (live rename entry)
//  rob_q_ready     in   NUM_READ        ROB reports queried entry has its result
//  rob_q_value     in   32*NUM_READ     that result
//  ckpt_save       in   1               snapshot rename table into slot ckpt_save_id
//  ckpt_save_id    in   CK_BIT          target slot
//  ckpt_restore    in   1               mispredict: replace live table with slot ckpt_restore_id
//  ckpt_restore_id in   CK_BIT          source slot
//  ckpt_release    in   1               branch resolved correctly: free slot ckpt_release_id
//  ckpt_release_id in   CK_BIT          slot to free
//  ckpt_valid      out  NUM_CKPT        per-slot valid flags
//  err_sticky      out  1               set on restore of invalid slot or save into valid slot; cleared only by reset
// BEHAVIOUR
//  Reset: all regs 0, all dirty 0, all rob entries 0, ckpt_valid 0, err_sticky 0; hence rd_val 0, rd_has_dep 0, rd_dep 0.
//  Reads are combinational (0-cycle) on pre-update state, per port p, priority order:
//   id==0 -> val 0, no dep; !dirty -> regs[id]; dirty & commit_valid & commit_rob_entry==entry -> commit_reg_data, no dep;
//   dirty & rob_q_ready -> rob_q_value, no dep; else has_dep=1, dep=entry. Same-cycle issue is NOT visible to reads.
//  Sequential priority: rst_in > !rdy_in (hold) > flush_all > ckpt_restore > normal update.
//  flush_all: dirty<=0, entries<=0, ckpt_valid<=0; regs keep values; commit in that cycle still writes regs.
//  Normal: commit (id!=0) writes regs[id]; clears live dirty only if live entry==commit_rob_entry;
//   issue (id!=0) sets dirty/entry, overriding a commit clear on the same register.
//  Commit also clears, in EVERY valid checkpoint, dirty of commit_reg_id where stored entry matches (checkpoints stay coherent).
//  ckpt_save: slot <= next-state live table (post commit, post issue of this cycle); slot valid<=1.
//  ckpt_restore (valid slot): live table <= slot contents with this cycle's commit clear applied; issue ignored;
//   restored slot and all slots saved after it stay valid only if not released; slot itself freed. Invalid slot: no change, err_sticky<=1.
//  ckpt_release: valid<=0. Release and save of same slot same cycle: save wins.
//  Register x0: never written, never dirty; writes/issues to x0 dropped silently.
// STRUCTURE
//  Shared package/Const.v: ROB_BIT, NUM_CKPT, CK_BIT, rename-entry struct {dirty, rob_entry}.
//  One sub-module: rename_ckpt_bank (NUM_CKPT snapshots, commit-coherent clear, save/restore/release).
// TESTING
//  Issue x5->ROB3; read x5, rob_q_ready=0 -> has_dep=1, dep=3; next cycle rob_q_ready=1,val=0x55 -> val 0x55, dep 0.
//  Commit x5 ROB3 data 0x11 same cycle as read of x5 -> val 0x11, has_dep 0; next cycle dirty clear, regs[5]=0x11.
//  Issue x7->ROB2, then x7->ROB6; commit ROB2 -> x7 still dirty, dep=6, regs[7] updated.
//  Save slot1 (x7 dirty ROB6), issue x7->ROB8, restore slot1 -> x7 dep=6; commit ROB6 before restore -> x7 clean.
//  flush_all with 3 dirty regs and 2 valid slots -> all has_dep 0, ckpt_valid 0, reg values retained.
//  Restore invalid slot -> table unchanged, err_sticky=1; rdy_in=0 with commit/issue -> no state change.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared widths and rename-table types for the architectural register file and its checkpoint bank.
package reg_rename_file_pkg;

  localparam int NUM_ARCH_REG = 32;
  localparam int REG_ID_BIT   = 5;
  localparam int DATA_BIT     = 32;
  localparam int ROB_BIT      = 4;
  localparam int NUM_CKPT     = 4;
  localparam int CK_BIT       = $clog2(NUM_CKPT);

  typedef struct packed {
    logic               dirty;
    logic [ROB_BIT-1:0] rob_entry;
  } rename_entry_t;

  typedef rename_entry_t [NUM_ARCH_REG-1:0] rename_table_t;

  // True when a commit of rob tag `rob` retires the producer recorded in `e`.
  function automatic logic entry_retired_by(rename_entry_t e, logic [ROB_BIT-1:0] rob);
    return e.dirty && (e.rob_entry == rob);
  endfunction

endpackage

// File: rtl/reg_rename_file_ckpt.sv
// Rename-table checkpoint bank: NUM_CKPT full snapshots kept coherent with commits,
// with save, restore (frees the slot) and release.
module rename_ckpt_bank
  import reg_rename_file_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_all,
  input  logic                  commit_fire,
  input  logic [REG_ID_BIT-1:0] commit_reg_id,
  input  logic [ROB_BIT-1:0]    commit_rob_entry,
  input  logic                  save_en,
  input  logic [CK_BIT-1:0]     save_id,
  input  rename_table_t         save_table,
  input  logic                  restore_en,
  input  logic [CK_BIT-1:0]     restore_id,
  input  logic                  release_en,
  input  logic [CK_BIT-1:0]     release_id,
  output rename_table_t         restore_table,
  output logic [NUM_CKPT-1:0]   valid
);

  rename_table_t tbl_view [NUM_CKPT];

  for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
    rename_table_t tbl_reg;
    logic          vld_reg;

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        tbl_reg <= '0;
        vld_reg <= 1'b0;
      end else if (rdy_in) begin
        if (flush_all) begin
          vld_reg <= 1'b0;
        end else if (save_en && (save_id == CK_BIT'(gi))) begin
          // A save already carries this cycle's commit, and beats a same-slot release.
          tbl_reg <= save_table;
          vld_reg <= 1'b1;
        end else begin
          if (vld_reg && commit_fire && entry_retired_by(tbl_reg[commit_reg_id], commit_rob_entry))
            tbl_reg[commit_reg_id].dirty <= 1'b0;
          if ((restore_en && (restore_id == CK_BIT'(gi))) ||
              (release_en && (release_id == CK_BIT'(gi))))
            vld_reg <= 1'b0;
        end
      end
    end

    assign tbl_view[gi] = tbl_reg;
    assign valid[gi]    = vld_reg;
  end

  assign restore_table = tbl_view[restore_id];

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus live rename table, with commit/ROB bypass on the
// decoder read ports and branch checkpoints for fast mispredict recovery.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int NUM_READ = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush_all,
  input  logic                           commit_valid,
  input  logic [REG_ID_BIT-1:0]          commit_reg_id,
  input  logic [DATA_BIT-1:0]            commit_reg_data,
  input  logic [ROB_BIT-1:0]             commit_rob_entry,
  input  logic                           issue_valid,
  input  logic [REG_ID_BIT-1:0]          issue_reg_id,
  input  logic [ROB_BIT-1:0]             issue_rob_entry,
  input  logic [REG_ID_BIT*NUM_READ-1:0] rd_id,
  output logic [DATA_BIT*NUM_READ-1:0]   rd_val,
  output logic [NUM_READ-1:0]            rd_has_dep,
  output logic [ROB_BIT*NUM_READ-1:0]    rd_dep,
  output logic [ROB_BIT*NUM_READ-1:0]    rob_q_entry,
  input  logic [NUM_READ-1:0]            rob_q_ready,
  input  logic [DATA_BIT*NUM_READ-1:0]   rob_q_value,
  input  logic                           ckpt_save,
  input  logic [CK_BIT-1:0]              ckpt_save_id,
  input  logic                           ckpt_restore,
  input  logic [CK_BIT-1:0]              ckpt_restore_id,
  input  logic                           ckpt_release,
  input  logic [CK_BIT-1:0]              ckpt_release_id,
  output logic [NUM_CKPT-1:0]            ckpt_valid,
  output logic                           err_sticky
);

  logic [DATA_BIT-1:0] regs_reg [NUM_ARCH_REG];
  rename_table_t       live_reg;
  rename_table_t       live_next;
  rename_table_t       ckpt_table;
  logic                err_reg;

  logic commit_fire;
  logic issue_fire;
  logic restore_hit;
  logic save_go;
  logic err_set;

  assign commit_fire = commit_valid && (commit_reg_id != '0);
  assign issue_fire  = issue_valid && (issue_reg_id != '0);
  assign restore_hit = ckpt_restore && ckpt_valid[ckpt_restore_id];
  // The branch being saved is squashed by a same-cycle restore, so its save is dropped.
  assign save_go     = ckpt_save && !ckpt_restore;
  assign err_set     = (ckpt_restore && !ckpt_valid[ckpt_restore_id]) ||
                       (save_go && ckpt_valid[ckpt_save_id] &&
                        !(ckpt_release && (ckpt_release_id == ckpt_save_id)));

  // Next live table; an invalid restore keeps the live table but still drops the issue.
  always_comb begin
    live_next = restore_hit ? ckpt_table : live_reg;
    if (commit_fire && entry_retired_by(live_next[commit_reg_id], commit_rob_entry))
      live_next[commit_reg_id].dirty = 1'b0;
    if (issue_fire && !ckpt_restore) begin
      live_next[issue_reg_id].dirty     = 1'b1;
      live_next[issue_reg_id].rob_entry = issue_rob_entry;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_ARCH_REG; i++) regs_reg[i] <= '0;
    end else if (rdy_in && commit_fire) begin
      regs_reg[commit_reg_id] <= commit_reg_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      live_reg <= '0;
      err_reg  <= 1'b0;
    end else if (rdy_in) begin
      if (flush_all) begin
        live_reg <= '0;
      end else begin
        live_reg <= live_next;
        if (err_set) err_reg <= 1'b1;
      end
    end
  end

  rename_ckpt_bank u_ckpt (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .flush_all        (flush_all),
    .commit_fire      (commit_fire),
    .commit_reg_id    (commit_reg_id),
    .commit_rob_entry (commit_rob_entry),
    .save_en          (save_go),
    .save_id          (ckpt_save_id),
    .save_table       (live_next),
    .restore_en       (restore_hit),
    .restore_id       (ckpt_restore_id),
    .release_en       (ckpt_release),
    .release_id       (ckpt_release_id),
    .restore_table    (ckpt_table),
    .valid            (ckpt_valid)
  );

  // Read ports see pre-update state; a same-cycle issue is deliberately invisible.
  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
    logic [REG_ID_BIT-1:0] id_w;
    rename_entry_t         ent_w;
    logic [DATA_BIT-1:0]   val_w;
    logic                  has_dep_w;
    logic [ROB_BIT-1:0]    dep_w;

    assign id_w  = rd_id[gi*REG_ID_BIT +: REG_ID_BIT];
    assign ent_w = live_reg[id_w];

    always_comb begin
      val_w     = '0;
      has_dep_w = 1'b0;
      dep_w     = '0;
      if (id_w == '0) begin
        val_w = '0;
      end else if (!ent_w.dirty) begin
        val_w = regs_reg[id_w];
      end else if (commit_valid && (commit_rob_entry == ent_w.rob_entry)) begin
        val_w = commit_reg_data;
      end else if (rob_q_ready[gi]) begin
        val_w = rob_q_value[gi*DATA_BIT +: DATA_BIT];
      end else begin
        has_dep_w = 1'b1;
        dep_w     = ent_w.rob_entry;
      end
    end

    assign rd_val[gi*DATA_BIT +: DATA_BIT]   = val_w;
    assign rd_has_dep[gi]                    = has_dep_w;
    assign rd_dep[gi*ROB_BIT +: ROB_BIT]     = dep_w;
    assign rob_q_entry[gi*ROB_BIT +: ROB_BIT] = ent_w.rob_entry;
  end

  assign err_sticky = err_reg;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed plus random bench for reg_rename_file against an array-based model of the rename rules.
module tb_reg_rename_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_all;
  logic        commit_valid, issue_valid;
  logic [4:0]  commit_reg_id, issue_reg_id;
  logic [31:0] commit_reg_data;
  logic [3:0]  commit_rob_entry, issue_rob_entry;
  logic [4:0]  rid [2];
  logic [31:0] qval [2];
  logic [1:0]  rob_q_ready;
  logic        ckpt_save, ckpt_restore, ckpt_release;
  logic [1:0]  ckpt_save_id, ckpt_restore_id, ckpt_release_id;

  logic [9:0]  rd_id;
  logic [63:0] rob_q_value;
  logic [63:0] rd_val;
  logic [1:0]  rd_has_dep;
  logic [7:0]  rd_dep, rob_q_entry;
  logic [3:0]  ckpt_valid;
  logic        err_sticky;

  assign rd_id       = {rid[1], rid[0]};
  assign rob_q_value = {qval[1], qval[0]};

  always #5 clk_in = ~clk_in;

  reg_rename_file #(.NUM_READ(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_all(flush_all),
    .commit_valid(commit_valid), .commit_reg_id(commit_reg_id),
    .commit_reg_data(commit_reg_data), .commit_rob_entry(commit_rob_entry),
    .issue_valid(issue_valid), .issue_reg_id(issue_reg_id), .issue_rob_entry(issue_rob_entry),
    .rd_id(rd_id), .rd_val(rd_val), .rd_has_dep(rd_has_dep), .rd_dep(rd_dep),
    .rob_q_entry(rob_q_entry), .rob_q_ready(rob_q_ready), .rob_q_value(rob_q_value),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
    .ckpt_release(ckpt_release), .ckpt_release_id(ckpt_release_id),
    .ckpt_valid(ckpt_valid), .err_sticky(err_sticky)
  );

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_dirty [32];
  logic [3:0]  m_ent [32];
  bit          m_cv [4];
  bit          m_cd [4][32];
  logic [3:0]  m_ce [4][32];
  bit          m_err;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0; m_dirty[r] = 0; m_ent[r] = '0;
      for (int s = 0; s < 4; s++) begin m_cd[s][r] = 0; m_ce[s][r] = '0; end
    end
    for (int s = 0; s < 4; s++) m_cv[s] = 0;
    m_err = 0;
  endtask

  function automatic void model_read(input int p, output logic [31:0] v, output logic h,
                                     output logic [3:0] d);
    int id;
    id = int'(rid[p]);
    v = '0; h = 0; d = '0;
    if (id == 0) v = '0;
    else if (!m_dirty[id]) v = m_regs[id];
    else if (commit_valid && commit_rob_entry == m_ent[id]) v = commit_reg_data;
    else if (rob_q_ready[p]) v = qval[p];
    else begin h = 1; d = m_ent[id]; end
  endfunction

  task automatic model_update();
    bit old_cv [4];
    bit cf;
    int cid, iid, sid;
    if (rst_in) begin model_reset(); return; end
    if (!rdy_in) return;
    cid = int'(commit_reg_id);
    iid = int'(issue_reg_id);
    cf  = commit_valid && cid != 0;
    if (cf) m_regs[cid] = commit_reg_data;
    if (flush_all) begin
      for (int r = 0; r < 32; r++) begin m_dirty[r] = 0; m_ent[r] = '0; end
      for (int s = 0; s < 4; s++) m_cv[s] = 0;
      return;
    end
    for (int s = 0; s < 4; s++) old_cv[s] = m_cv[s];
    if (ckpt_restore) begin
      sid = int'(ckpt_restore_id);
      if (old_cv[sid]) begin
        for (int r = 0; r < 32; r++) begin m_dirty[r] = m_cd[sid][r]; m_ent[r] = m_ce[sid][r]; end
        m_cv[sid] = 0;
      end else m_err = 1;
      if (cf && m_dirty[cid] && m_ent[cid] == commit_rob_entry) m_dirty[cid] = 0;
    end else begin
      if (cf && m_dirty[cid] && m_ent[cid] == commit_rob_entry) m_dirty[cid] = 0;
      if (issue_valid && iid != 0) begin m_dirty[iid] = 1; m_ent[iid] = issue_rob_entry; end
    end
    for (int s = 0; s < 4; s++)
      if (old_cv[s] && cf && m_cd[s][cid] && m_ce[s][cid] == commit_rob_entry) m_cd[s][cid] = 0;
    if (ckpt_release) m_cv[int'(ckpt_release_id)] = 0;
    if (!ckpt_restore && ckpt_save) begin
      sid = int'(ckpt_save_id);
      if (old_cv[sid] && !(ckpt_release && ckpt_release_id == ckpt_save_id)) m_err = 1;
      for (int r = 0; r < 32; r++) begin m_cd[sid][r] = m_dirty[r]; m_ce[sid][r] = m_ent[r]; end
      m_cv[sid] = 1;
    end
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; flush_all = 0;
    commit_valid = 0; commit_reg_id = '0; commit_reg_data = '0; commit_rob_entry = '0;
    issue_valid = 0; issue_reg_id = '0; issue_rob_entry = '0;
    rob_q_ready = '0; qval[0] = '0; qval[1] = '0;
    ckpt_save = 0; ckpt_restore = 0; ckpt_release = 0;
    ckpt_save_id = '0; ckpt_restore_id = '0; ckpt_release_id = '0;
  endtask

  // Let combinational outputs settle, then compare every output against the model.
  task automatic settle();
    logic [31:0] v; logic h; logic [3:0] d;
    logic [3:0] cv;
    #2;
    for (int p = 0; p < 2; p++) begin
      model_read(p, v, h, d);
      check($sformatf("rd_val[%0d] x%0d", p, rid[p]), rd_val[p*32 +: 32], v);
      check($sformatf("rd_has_dep[%0d] x%0d", p, rid[p]), 32'(rd_has_dep[p]), 32'(h));
      check($sformatf("rd_dep[%0d] x%0d", p, rid[p]), 32'(rd_dep[p*4 +: 4]), 32'(d));
      check($sformatf("rob_q_entry[%0d] x%0d", p, rid[p]), 32'(rob_q_entry[p*4 +: 4]),
            32'(m_ent[int'(rid[p])]));
    end
    for (int s = 0; s < 4; s++) cv[s] = m_cv[s];
    check("ckpt_valid", 32'(ckpt_valid), 32'(cv));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_update();
    @(negedge clk_in);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    idle();
    rid[0] = '0; rid[1] = '0;
    rst_in = 1;
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 0;

    // Reset state
    rid[0] = 5'd5; rid[1] = 5'd7;
    step();

    // Issue x5 -> ROB3, then dependency and ROB bypass
    issue_valid = 1; issue_reg_id = 5; issue_rob_entry = 3;
    step();
    idle();
    settle();
    check("x5_dep_flag", 32'(rd_has_dep[0]), 32'd1);
    check("x5_dep_id", 32'(rd_dep[3:0]), 32'd3);
    tick();
    rob_q_ready = 2'b01; qval[0] = 32'h55;
    settle();
    check("x5_rob_bypass", rd_val[31:0], 32'h55);
    tick();

    // Commit bypass then architectural value
    idle(); commit_valid = 1; commit_reg_id = 5; commit_reg_data = 32'h11; commit_rob_entry = 3;
    settle();
    check("x5_commit_bypass", rd_val[31:0], 32'h11);
    tick();
    idle();
    settle();
    check("x5_committed", rd_val[31:0], 32'h11);
    check("x5_clean", 32'(rd_has_dep[0]), 32'd0);
    tick();

    // Older commit must not clear a newer rename
    issue_valid = 1; issue_reg_id = 7; issue_rob_entry = 2; step();
    issue_rob_entry = 6; step();
    idle(); commit_valid = 1; commit_reg_id = 7; commit_reg_data = 32'h77; commit_rob_entry = 2;
    step();
    idle();
    settle();
    check("x7_still_dep", 32'(rd_dep[7:4]), 32'd6);
    tick();

    // Save / restore of slot 1
    ckpt_save = 1; ckpt_save_id = 1; step();
    idle(); issue_valid = 1; issue_reg_id = 7; issue_rob_entry = 8; step();
    idle();
    settle();
    check("x7_dep_rob8", 32'(rd_dep[7:4]), 32'd8);
    tick();
    ckpt_restore = 1; ckpt_restore_id = 1; step();
    idle();
    settle();
    check("x7_restored_dep", 32'(rd_dep[7:4]), 32'd6);
    check("slot1_freed", 32'(ckpt_valid[1]), 32'd0);
    tick();

    // Commit of the checkpointed producer before restore leaves x7 clean
    ckpt_save = 1; ckpt_save_id = 1; step();
    idle(); issue_valid = 1; issue_reg_id = 7; issue_rob_entry = 8; step();
    idle(); commit_valid = 1; commit_reg_id = 7; commit_reg_data = 32'h66; commit_rob_entry = 6;
    step();
    idle(); ckpt_restore = 1; ckpt_restore_id = 1; step();
    idle();
    settle();
    check("x7_clean_after_restore", 32'(rd_has_dep[1]), 32'd0);
    check("x7_val_after_restore", rd_val[63:32], 32'h66);
    tick();

    // Flush with three dirty registers and two valid slots
    issue_valid = 1; issue_reg_id = 3; issue_rob_entry = 1; ckpt_save = 1; ckpt_save_id = 0; step();
    issue_reg_id = 4; issue_rob_entry = 2; ckpt_save_id = 2; step();
    idle(); issue_valid = 1; issue_reg_id = 7; issue_rob_entry = 9; step();
    idle(); flush_all = 1; rid[0] = 3; rid[1] = 4; step();
    idle();
    settle();
    check("flush_dep0", 32'(rd_has_dep), 32'd0);
    check("flush_ckpt", 32'(ckpt_valid), 32'd0);
    tick();
    rid[0] = 7;
    settle();
    check("flush_keeps_x7", rd_val[31:0], 32'h66);
    tick();

    // Restore of invalid slot, then hold with rdy low
    ckpt_restore = 1; ckpt_restore_id = 3; step();
    idle();
    settle();
    check("err_after_bad_restore", 32'(err_sticky), 32'd1);
    tick();
    rdy_in = 0; commit_valid = 1; commit_reg_id = 9; commit_reg_data = 32'hdead; commit_rob_entry = 1;
    issue_valid = 1; issue_reg_id = 9; issue_rob_entry = 5; rid[0] = 9;
    step();
    idle(); rid[0] = 9;
    settle();
    check("hold_x9_val", rd_val[31:0], 32'h0);
    tick();

    // Random phase
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy_in       = ($urandom % 8) != 0;
      flush_all    = ($urandom % 50) == 0;
      commit_valid = $urandom % 2;
      commit_reg_id = 5'($urandom_range(0, 7));
      commit_reg_data = $urandom;
      commit_rob_entry = ($urandom % 2) ? m_ent[int'(commit_reg_id)] : 4'($urandom);
      issue_valid  = $urandom % 2;
      issue_reg_id = 5'($urandom_range(0, 7));
      issue_rob_entry = 4'($urandom);
      rid[0] = 5'($urandom_range(0, 7));
      rid[1] = 5'($urandom_range(0, 7));
      rob_q_ready = 2'($urandom);
      qval[0] = $urandom; qval[1] = $urandom;
      ckpt_save    = ($urandom % 5) == 0;
      ckpt_save_id = 2'($urandom);
      ckpt_restore = ($urandom % 9) == 0;
      ckpt_restore_id = 2'($urandom);
      ckpt_release = ($urandom % 6) == 0;
      ckpt_release_id = 2'($urandom);
      step();
    end

    idle();
    settle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
